rr_hazard_ctrl: RTL and testbench
=================================

Name: rr_hazard_ctrl

Overview:
- Issue controller for the RF-read (RR) pipeline stage.
- Keeps a per-register scoreboard of in-flight writes (8 regs x 16 bit).
- Interlocks RR on RAW and WAW hazards and gates the RR->EX register load.
- Generates pipeline flush on taken branches and sequences an orderly drain/halt of the pipeline.

Parameters:
- FLUSH_CYCLES, 1: cycles spent in FLUSH state after a taken branch (>=1).
- STALL_CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rr_valid  in  1  RR stage holds a valid instruction
- rr_rx  in  3  source register X
- rr_ry  in  3  source register Y
- rr_use_rx  in  1  instruction reads Rx
- rr_use_ry  in  1  instruction reads Ry
- rr_wr_en  in  1  instruction writes a register
- rr_rd  in  3  destination register
- ex_ready  in  1  EX stage can accept an instruction
- ex_br_taken  in  1  EX resolved a taken branch this cycle
- wb_wr_en  in  1  WB writes the register file this cycle
- wb_rd  in  3  WB destination register
- drain_req  in  1  request to stop issue and empty the pipeline
- rr_issue  out  1  load the RR->EX register with the RR instruction
- rr_stall  out  1  hold fetch and RR contents
- flush  out  1  kill fetch/RR contents; load a bubble into RR->EX
- drained  out  1  pipeline empty, issue halted
- pending  out  8  scoreboard, bit i = write to Ri in flight
- stall_count  out  STALL_CNT_W  saturating count of stall cycles
- fwd_x  out  1  Rx operand taken from the WB bypass
- fwd_y  out  1  Ry operand taken from the WB bypass

Behaviour:
- Reset (async, active-high):
  - state=RUN, pending=0, stall_count=0, flush counter=0.
  - All outputs are 0 while reset is asserted.
- Effective pending, epend: equals pending (see FORWARD_EN).
- Hazard, combinational: hz = rr_valid & ((rr_use_rx & epend[rr_rx]) | (rr_use_ry & epend[rr_ry]) | (rr_wr_en & epend[rr_rd])).
- Issue: rr_issue = rr_valid & ~hz & ex_ready & ~ex_br_taken & (state==RUN).
- Stall: rr_stall = rr_valid & ~rr_issue & ~flush.
- Flush: flush = ex_br_taken | (state==FLUSH). Flush has priority over stall.
- Scoreboard update at each clock edge:
  - Set pending[rr_rd] if rr_issue & rr_wr_en.
  - Clear pending[wb_rd] if wb_wr_en.
  - Set and clear on the same register in the same cycle: set wins.
  - Clearing a bit that is already 0 has no effect.
  - Flushed instructions never set pending, because they never issued.
- stall_count increments on each cycle with rr_stall=1 and saturates at all-ones.
- FSM:
  - RUN:
    - ex_br_taken -> FLUSH, loading the counter with FLUSH_CYCLES-1.
    - Else drain_req -> DRAIN.
    - Branch has priority over drain.
  - FLUSH:
    - flush=1 and rr_issue=0.
    - Counter decrements each cycle; at 0 -> RUN.
    - ex_br_taken is ignored in this state.
  - DRAIN:
    - rr_issue=0; flush follows ex_br_taken.
    - When pending==0 and wb_wr_en==0 -> HALTED.
  - HALTED:
    - drained=1, rr_issue=0.
    - drain_req=0 -> RUN on the next cycle.
- Latency: the scoreboard is visible the cycle after issue. Without bypass, a dependent instruction issues the cycle after WB writes.
- Reset mid-operation discards all in-flight scoreboard state.

Optional Feature:
- Macro: RR_WB_FORWARD_EN.
- Defined:
  - epend = pending & ~(wb_wr_en ? onehot(wb_rd) : 0).
  - fwd_x = rr_issue & rr_use_rx & wb_wr_en & (rr_rx==wb_rd).
  - fwd_y is formed the same way from rr_use_ry and rr_ry.
  - A RAW dependency on the register currently being written back issues in the same cycle, saving one stall.
- Undefined:
  - epend = pending.
  - fwd_x and fwd_y are tied to 0.

Test Plan:
- Reset with random inputs -> all outputs 0, pending=8'h00. After release, state is RUN.
- Issue ADD R3 (rr_wr_en=1, rr_rd=3), then a reader of R3 next cycle:
  - pending=8'h08, rr_stall=1 until a WB write of R3.
  - Issues the cycle after the write; with RR_WB_FORWARD_EN it issues in the WB cycle with fwd_x=1.
  - stall_count matches the number of stalled cycles.
- WAW: pending[5]=1 and the RR instruction writes R5 -> rr_stall=1, no issue, until wb_rd=5.
- ex_br_taken=1 with FLUSH_CYCLES=2 -> flush=1 for 3 consecutive cycles, rr_issue=0 throughout, pending unchanged by the flushed instruction.
- drain_req=1 with pending=8'h11:
  - rr_issue=0.
  - drained=1 one cycle after the last WB clears both bits.
  - drain_req=0 -> issue resumes.
- Simultaneous issue writing R2 and WB write of R2 (forward build) -> pending[2]=1 afterwards (set wins). Stall counter saturates at 16'hFFFF under a held hazard.

Source files
------------

// File: rtl/rr_hazard_ctrl_if.sv
// RR-stage hazard controller bundle: pipeline-side requests into the
// controller and issue/stall/flush/scoreboard status back out.
//
// Signals (master = pipeline, slave = controller):
//   rr_valid, rr_rx, rr_ry, rr_use_rx, rr_use_ry   RR instruction operands
//   rr_wr_en, rr_rd                                RR instruction destination
//   ex_ready, ex_br_taken                          EX acceptance / branch
//   wb_wr_en, wb_rd                                WB register-file write
//   drain_req                                      stop issue and empty pipe
//   rr_issue, rr_stall, flush, drained             control outputs
//   pending                                        scoreboard, bit i = Ri busy
//   stall_count                                    saturating stall cycles
//   fwd_x, fwd_y                                   WB bypass selects
interface rr_hazard_ctrl_if #(
   parameter int STALL_CNT_W = 16
);
   logic                   rr_valid;
   logic [2:0]             rr_rx;
   logic [2:0]             rr_ry;
   logic                   rr_use_rx;
   logic                   rr_use_ry;
   logic                   rr_wr_en;
   logic [2:0]             rr_rd;
   logic                   ex_ready;
   logic                   ex_br_taken;
   logic                   wb_wr_en;
   logic [2:0]             wb_rd;
   logic                   drain_req;
   logic                   rr_issue;
   logic                   rr_stall;
   logic                   flush;
   logic                   drained;
   logic [7:0]             pending;
   logic [STALL_CNT_W-1:0] stall_count;
   logic                   fwd_x;
   logic                   fwd_y;

   modport master (
      output rr_valid, rr_rx, rr_ry, rr_use_rx, rr_use_ry,
      output rr_wr_en, rr_rd, ex_ready, ex_br_taken,
      output wb_wr_en, wb_rd, drain_req,
      input  rr_issue, rr_stall, flush, drained,
      input  pending, stall_count, fwd_x, fwd_y
   );

   modport slave (
      input  rr_valid, rr_rx, rr_ry, rr_use_rx, rr_use_ry,
      input  rr_wr_en, rr_rd, ex_ready, ex_br_taken,
      input  wb_wr_en, wb_rd, drain_req,
      output rr_issue, rr_stall, flush, drained,
      output pending, stall_count, fwd_x, fwd_y
   );
endinterface

// File: rtl/rr_hazard_ctrl.sv
// RR-stage issue controller: 8-entry write scoreboard, RAW/WAW interlock,
// branch flush sequencing and orderly drain/halt of the pipeline.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    rr_hazard_ctrl_if.slave (see interface file for signal list)
//
// Parameters:
//   FLUSH_CYCLES  cycles spent in FLUSH after a taken branch (>=1)
//   STALL_CNT_W   width of the saturating stall counter
//
// Optional feature macro: RR_WB_FORWARD_EN
//   Defined:   the register being written back this cycle is treated as
//              ready, and fwd_x/fwd_y select the WB bypass for it.
//   Undefined: a dependent instruction waits until the cycle after WB;
//              fwd_x/fwd_y are tied low.
module rr_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int STALL_CNT_W  = 16
) (
   input  logic            clk,
   input  logic            reset,
   rr_hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_RUN,
      S_FLUSH,
      S_DRAIN,
      S_HALT
   } state_t;

   localparam int FCW =
      (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
   localparam logic [FCW-1:0] FCNT_ONE   = FCW'(1);
   localparam logic [STALL_CNT_W-1:0] SCNT_ONE = STALL_CNT_W'(1);

   state_t                 state_q;
   state_t                 state_d;
   logic [FCW-1:0]         fcnt_q;
   logic [FCW-1:0]         fcnt_d;
   logic [7:0]             pend_q;
   logic [7:0]             pend_d;
   logic [STALL_CNT_W-1:0] scnt_q;
   logic [STALL_CNT_W-1:0] scnt_d;

   logic [7:0] wb_oh;
   logic [7:0] rd_oh;
   logic [7:0] epend;
   logic       hz;
   logic       issue;
   logic       stall;
   logic       flush_w;
   logic       drained_w;
   logic       fwd_x_w;
   logic       fwd_y_w;

   // ---------------------------------------------------------------
   // Scoreboard view used by the interlock
   // ---------------------------------------------------------------
   always_comb begin
      wb_oh = 8'h00;
      if (bus.wb_wr_en) begin
         wb_oh = 8'h01 << bus.wb_rd;
      end
   end

   always_comb begin
      rd_oh = 8'h00;
      if (issue && bus.rr_wr_en) begin
         rd_oh = 8'h01 << bus.rr_rd;
      end
   end

`ifdef RR_WB_FORWARD_EN
   // A register completing in WB this cycle can be bypassed, so it
   // no longer blocks the RR instruction.
   assign epend = pend_q & ~wb_oh;
`else
   assign epend = pend_q;
`endif

   assign hz = bus.rr_valid &
               ((bus.rr_use_rx & epend[bus.rr_rx]) |
                (bus.rr_use_ry & epend[bus.rr_ry]) |
                (bus.rr_wr_en  & epend[bus.rr_rd]));

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         S_RUN: begin
            // Branch wins over a simultaneous drain request.
            if (bus.ex_br_taken) begin
               state_d = S_FLUSH;
               fcnt_d  = FLUSH_LOAD;
            end else if (bus.drain_req) begin
               state_d = S_DRAIN;
            end
         end
         S_FLUSH: begin
            if (fcnt_q == '0) begin
               state_d = S_RUN;
            end else begin
               fcnt_d = fcnt_q - FCNT_ONE;
            end
         end
         S_DRAIN: begin
            // Wait until nothing is in flight and no write is landing.
            if ((pend_q == 8'h00) && !bus.wb_wr_en) begin
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            if (!bus.drain_req) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs (all forced low while reset is held)
   // ---------------------------------------------------------------
   always_comb begin
      issue     = 1'b0;
      flush_w   = 1'b0;
      stall     = 1'b0;
      drained_w = 1'b0;
      if (!reset) begin
         issue     = bus.rr_valid & ~hz & bus.ex_ready &
                     ~bus.ex_br_taken & (state_q == S_RUN);
         flush_w   = bus.ex_br_taken | (state_q == S_FLUSH);
         stall     = bus.rr_valid & ~issue & ~flush_w;
         drained_w = (state_q == S_HALT);
      end
   end

`ifdef RR_WB_FORWARD_EN
   assign fwd_x_w = issue & bus.rr_use_rx & bus.wb_wr_en &
                    (bus.rr_rx == bus.wb_rd);
   assign fwd_y_w = issue & bus.rr_use_ry & bus.wb_wr_en &
                    (bus.rr_ry == bus.wb_rd);
`else
   assign fwd_x_w = 1'b0;
   assign fwd_y_w = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Scoreboard and stall counter
   // ---------------------------------------------------------------
   // Set is applied after clear so a same-register set/clear keeps
   // the bit: the newly issued write is still outstanding.
   assign pend_d = (pend_q & ~wb_oh) | rd_oh;

   always_comb begin
      scnt_d = scnt_q;
      if (stall && (scnt_q != '1)) begin
         scnt_d = scnt_q + SCNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= 8'h00;
         scnt_q <= '0;
      end else begin
         pend_q <= pend_d;
         scnt_q <= scnt_d;
      end
   end

   assign bus.rr_issue    = issue;
   assign bus.rr_stall    = stall;
   assign bus.flush       = flush_w;
   assign bus.drained     = drained_w;
   assign bus.pending     = pend_q;
   assign bus.stall_count = scnt_q;
   assign bus.fwd_x       = fwd_x_w;
   assign bus.fwd_y       = fwd_y_w;

endmodule

// File: tb/tb_rr_hazard_ctrl.sv
// Directed, table-driven bench for rr_hazard_ctrl (FLUSH_CYCLES=2).
// Expectations adapt to RR_WB_FORWARD_EN where bypass changes timing.
module tb_rr_hazard_ctrl;

   localparam int SW = 16;

`ifdef RR_WB_FORWARD_EN
   localparam logic F = 1'b1;
`else
   localparam logic F = 1'b0;
`endif

   logic clk;
   logic reset;

   rr_hazard_ctrl_if #(.STALL_CNT_W(SW)) bus ();

   rr_hazard_ctrl #(
      .FLUSH_CYCLES(2),
      .STALL_CNT_W (SW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [2:0] rx;
      logic [2:0] ry;
      logic       urx;
      logic       ury;
      logic       wr;
      logic [2:0] rd;
      logic       exr;
      logic       br;
      logic       wbw;
      logic [2:0] wbrd;
      logic       drn;
      logic       e_iss;
      logic       e_stl;
      logic       e_fl;
      logic       e_drd;
      logic       e_fx;
      logic [7:0] e_pend;
   } vec_t;

   vec_t tbl[$];
   int   n_chk;
   int   n_pass;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, a, e);
   endtask

   task automatic add(
      input logic v, input logic [2:0] rx, input logic [2:0] ry,
      input logic urx, input logic ury, input logic wr,
      input logic [2:0] rd, input logic exr, input logic br,
      input logic wbw, input logic [2:0] wbrd, input logic drn,
      input logic iss, input logic stl, input logic fl,
      input logic drd, input logic fx, input logic [7:0] pend);
      vec_t r;
      r.v = v; r.rx = rx; r.ry = ry; r.urx = urx; r.ury = ury;
      r.wr = wr; r.rd = rd; r.exr = exr; r.br = br;
      r.wbw = wbw; r.wbrd = wbrd; r.drn = drn;
      r.e_iss = iss; r.e_stl = stl; r.e_fl = fl; r.e_drd = drd;
      r.e_fx = fx; r.e_pend = pend;
      tbl.push_back(r);
   endtask

   task automatic drive(input vec_t r);
      bus.rr_valid    = r.v;
      bus.rr_rx       = r.rx;
      bus.rr_ry       = r.ry;
      bus.rr_use_rx   = r.urx;
      bus.rr_use_ry   = r.ury;
      bus.rr_wr_en    = r.wr;
      bus.rr_rd       = r.rd;
      bus.ex_ready    = r.exr;
      bus.ex_br_taken = r.br;
      bus.wb_wr_en    = r.wbw;
      bus.wb_rd       = r.wbrd;
      bus.drain_req   = r.drn;
   endtask

   task automatic idle();
      vec_t r;
      r = '{default: '0};
      drive(r);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".issue"},   32'(bus.rr_issue),    32'd0);
      chk({nm, ".stall"},   32'(bus.rr_stall),    32'd0);
      chk({nm, ".flush"},   32'(bus.flush),       32'd0);
      chk({nm, ".drained"}, 32'(bus.drained),     32'd0);
      chk({nm, ".pending"}, 32'(bus.pending),     32'd0);
      chk({nm, ".scnt"},    32'(bus.stall_count), 32'd0);
      chk({nm, ".fwd_x"},   32'(bus.fwd_x),       32'd0);
      chk({nm, ".fwd_y"},   32'(bus.fwd_y),       32'd0);
   endtask

   initial begin
      vec_t r;
      int   exp_cnt;
      n_chk  = 0;
      n_pass = 0;

      //  v rx ry ux uy wr rd er br ww wr dr | is st fl dd fx pend
      add(1, 1, 2, 1, 1, 1, 3, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'h00);
      add(1, 3, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 8'h08);
      add(1, 3, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 8'h08);
      add(1, 3, 0, 1, 0, 0, 0, 1, 0, 1, 3, 0,  F, !F, 0, 0, F, 8'h08);
      add(1, 3, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'h00);
      // WAW on R5
      add(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'h00);
      add(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 8'h20);
      add(1, 0, 0, 0, 0, 1, 5, 1, 0, 1, 1, 0,  0, 1, 0, 0, 0, 8'h20);
      add(1, 0, 0, 0, 0, 1, 5, 1, 0, 1, 5, 0,  F, !F, 0, 0, 0, 8'h20);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5, 0,  0, 0, 0, 0, 0,
          F ? 8'h20 : 8'h00);
      // taken branch, two FLUSH cycles follow
      add(1, 0, 0, 0, 0, 1, 6, 1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 8'h00);
      add(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 8'h00);
      add(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 8'h00);
      add(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'h00);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6, 0,  0, 0, 0, 0, 0, 8'h40);
      // EX not ready
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 8'h00);
      // drain with R0 and R4 in flight
      add(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'h00);
      add(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'h01);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 8'h11);
      add(1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 8'h11);
      add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1,  0, 0, 1, 0, 0, 8'h11);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4, 1,  0, 0, 0, 0, 0, 8'h10);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 8'h00);
      add(1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1,  0, 1, 0, 1, 0, 8'h00);
      add(1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 0, 8'h00);
      add(1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'h00);

      // reset held with random inputs
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         bus.rr_valid    = 1'($urandom);
         bus.rr_rx       = 3'($urandom);
         bus.rr_ry       = 3'($urandom);
         bus.rr_use_rx   = 1'($urandom);
         bus.rr_use_ry   = 1'($urandom);
         bus.rr_wr_en    = 1'($urandom);
         bus.rr_rd       = 3'($urandom);
         bus.ex_ready    = 1'($urandom);
         bus.ex_br_taken = 1'($urandom);
         bus.wb_wr_en    = 1'($urandom);
         bus.wb_rd       = 3'($urandom);
         bus.drain_req   = 1'($urandom);
         @(negedge clk);
         chk_zero($sformatf("rst%0d", k));
      end
      idle();
      reset = 1'b0;

      exp_cnt = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         r = tbl[i];
         @(posedge clk);
         #1;
         drive(r);
         @(negedge clk);
         chk($sformatf("row%0d.issue", i),
             32'(bus.rr_issue), 32'(r.e_iss));
         chk($sformatf("row%0d.stall", i),
             32'(bus.rr_stall), 32'(r.e_stl));
         chk($sformatf("row%0d.flush", i),
             32'(bus.flush), 32'(r.e_fl));
         chk($sformatf("row%0d.drained", i),
             32'(bus.drained), 32'(r.e_drd));
         chk($sformatf("row%0d.fwd_x", i),
             32'(bus.fwd_x), 32'(r.e_fx));
         chk($sformatf("row%0d.fwd_y", i),
             32'(bus.fwd_y), 32'd0);
         chk($sformatf("row%0d.pending", i),
             32'(bus.pending), 32'(r.e_pend));
         chk($sformatf("row%0d.scnt", i),
             32'(bus.stall_count), 32'(exp_cnt));
         exp_cnt += int'(r.e_stl);
      end

      // same-cycle issue-write and WB of R2: set wins
      @(posedge clk);
      #1;
      idle();
      bus.rr_valid = 1'b1;
      bus.rr_wr_en = 1'b1;
      bus.rr_rd    = 3'd2;
      bus.ex_ready = 1'b1;
      bus.wb_wr_en = 1'b1;
      bus.wb_rd    = 3'd2;
      @(negedge clk);
      chk("setwin.issue", 32'(bus.rr_issue), 32'd1);
      @(posedge clk);
      #1;
      idle();
      bus.ex_ready = 1'b1;
      @(negedge clk);
      chk("setwin.pending", 32'(bus.pending), 32'h04);

      // issue write R7, then hold a dependent reader until saturation
      @(posedge clk);
      #1;
      idle();
      bus.rr_valid = 1'b1;
      bus.rr_wr_en = 1'b1;
      bus.rr_rd    = 3'd7;
      bus.ex_ready = 1'b1;
      @(negedge clk);
      chk("sat.w7.issue", 32'(bus.rr_issue), 32'd1);
      @(posedge clk);
      #1;
      idle();
      bus.rr_valid  = 1'b1;
      bus.rr_rx     = 3'd7;
      bus.rr_use_rx = 1'b1;
      bus.ex_ready  = 1'b1;
      repeat (65540) @(posedge clk);
      @(negedge clk);
      chk("sat.scnt", 32'(bus.stall_count), 32'h0000_FFFF);
      chk("sat.stall", 32'(bus.rr_stall), 32'd1);
      chk("sat.pending", 32'(bus.pending), 32'h84);
      @(negedge clk);
      chk("sat.hold", 32'(bus.stall_count), 32'h0000_FFFF);

      // reset mid-operation discards the scoreboard
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst.issue", 32'(bus.rr_issue), 32'd1);
      chk("midrst.stall", 32'(bus.rr_stall), 32'd0);
      chk("midrst.pending", 32'(bus.pending), 32'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
